// File: rtl/fir_mac_param.sv
`default_nettype none
// ============================================================================
// Module      : fir_mac_param
// Description : Serial-MAC FIR filter with runtime-loadable coefficients.
//               A single multiplier is time-shared across all TAPS taps. Each
//               accepted sample starts one convolution. The result is given
//               at full precision (o_y) and also arithmetic-shifted and
//               saturated to OUT_W bits (o_y_sat).
// Ports       : i_clk, i_rst_n        clock (rising edge), async active-low reset
//               i_ready, i_x          one-cycle new-sample strobe and sample
//               i_coef_we/addr/data   coefficient write port (ignored while busy)
//               i_clear_overrun       synchronous clear of o_overrun
//               o_y, o_y_sat          filter outputs, held between updates
//               o_y_valid             one-cycle pulse when outputs update
//               o_busy                convolution in progress
//               o_overrun             sticky: sample arrived while busy
// Revision    : 1.0 - initial release
// ============================================================================
module fir_mac_param #(
  parameter int TAPS      = 31,
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 10,
  parameter int ACC_W     = 24,
  parameter int OUT_SHIFT = 10,
  parameter int OUT_W     = 8,
  parameter int AW        = 7
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ready,
  input  logic [DATA_W-1:0] i_x,
  input  logic              i_coef_we,
  input  logic [AW-1:0]     i_coef_addr,
  input  logic [COEF_W-1:0] i_coef_data,
  input  logic              i_clear_overrun,
  output logic [ACC_W-1:0]  o_y,
  output logic [OUT_W-1:0]  o_y_sat,
  output logic              o_y_valid,
  output logic              o_busy,
  output logic              o_overrun
);

  localparam int P_W = DATA_W + COEF_W;
  localparam logic [AW-1:0] c_LAST = AW'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] c_SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] c_SAT_MIN = ~c_SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DATA_W-1:0]       r_samp [TAPS];
  logic [COEF_W-1:0]       r_coef [TAPS];
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [AW-1:0]           r_k;
  logic [P_W-1:0]          r_prod;
  logic signed [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0]        r_y;
  logic [OUT_W-1:0]        r_y_sat;
  logic                    r_y_valid;
  logic                    r_overrun;

  logic                    w_idle;
  logic                    w_busy;
  logic                    w_coef_ok;
  logic [P_W-1:0]          w_coef_ext;
  logic [P_W-1:0]          w_samp_ext;
  logic [P_W-1:0]          w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_shift;
  logic [OUT_W-1:0]        w_sat;

  // The FSM is back in IDLE during the y_valid cycle, so a sample arriving
  // then is accepted, while o_busy still reports that cycle as busy.
  assign w_idle = (r_state == S_IDLE);
  assign w_busy = !w_idle || r_y_valid;

  // Widen the address by one bit so TAPS == 2**AW compares correctly.
  assign w_coef_ok = i_coef_we && !w_busy &&
                     ({1'b0, i_coef_addr} < (AW + 1)'(TAPS));

  // Both operands sign-extended to P_W: the low P_W bits of the product are
  // the exact signed product, which always fits in P_W bits.
  assign w_coef_ext = {{DATA_W{r_coef[r_k][COEF_W-1]}}, r_coef[r_k]};
  assign w_samp_ext = {{COEF_W{r_samp[r_rd_ptr][DATA_W-1]}}, r_samp[r_rd_ptr]};
  assign w_prod     = w_coef_ext * w_samp_ext;
  assign w_prod_ext = {{(ACC_W - P_W){r_prod[P_W-1]}}, r_prod};

  // Floor division by 2**OUT_SHIFT, then clamp into OUT_W signed range.
  assign w_shift = r_acc >>> OUT_SHIFT;

  always_comb begin
    w_sat = w_shift[OUT_W-1:0];
    if (w_shift > c_SAT_MAX) begin
      w_sat = c_SAT_MAX[OUT_W-1:0];
    end else if (w_shift < c_SAT_MIN) begin
      w_sat = c_SAT_MIN[OUT_W-1:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_ready) w_next = S_MAC;
      S_MAC:   if (r_k == c_LAST) w_next = S_FLUSH;
      S_FLUSH: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        r_samp[i] <= '0;
        r_coef[i] <= '0;
      end
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_k       <= '0;
      r_prod    <= '0;
      r_acc     <= '0;
      r_y       <= '0;
      r_y_sat   <= '0;
      r_y_valid <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_y_valid <= 1'b0;

      if (w_coef_ok) begin
        r_coef[i_coef_addr] <= i_coef_data;
      end

      // A new overrun event takes priority over a simultaneous clear.
      if (i_ready && !w_idle) begin
        r_overrun <= 1'b1;
      end else if (i_clear_overrun) begin
        r_overrun <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (i_ready) begin
            r_samp[r_wr_ptr] <= i_x;
            r_rd_ptr         <= r_wr_ptr;
            r_wr_ptr         <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + AW'(1);
            r_acc            <= '0;
            r_prod           <= '0;
            r_k              <= '0;
          end
        end
        S_MAC: begin
          // The product register lags by one tap; FLUSH adds the last one.
          r_prod   <= w_prod;
          r_acc    <= r_acc + w_prod_ext;
          r_k      <= r_k + AW'(1);
          r_rd_ptr <= (r_rd_ptr == '0) ? c_LAST : r_rd_ptr - AW'(1);
        end
        S_FLUSH: begin
          r_acc <= r_acc + w_prod_ext;
        end
        S_DONE: begin
          r_y       <= r_acc;
          r_y_sat   <= w_sat;
          r_y_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_y       = r_y;
  assign o_y_sat   = r_y_sat;
  assign o_y_valid = r_y_valid;
  assign o_busy    = w_busy;
  assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_mac_param
// Description : Self-checking bench for fir_mac_param (default parameters).
//               Expected outputs come from a direct-form FIR model: a history
//               array with the newest sample at index 0, dot product with the
//               coefficient array, floor shift and clamp.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_mac_param;

  localparam int TAPS = 31;

  logic        clk;
  logic        rst_n;
  logic        ready;
  logic [7:0]  x;
  logic        coef_we;
  logic [6:0]  coef_addr;
  logic [9:0]  coef_data;
  logic        clear_overrun;
  logic [23:0] y;
  logic [7:0]  y_sat;
  logic        y_valid;
  logic        busy;
  logic        overrun;

  int total = 0;
  int bad   = 0;
  int vcount = 0;

  int coef_m [TAPS];
  int hist   [TAPS];

  fir_mac_param dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_ready         (ready),
    .i_x             (x),
    .i_coef_we       (coef_we),
    .i_coef_addr     (coef_addr),
    .i_coef_data     (coef_data),
    .i_clear_overrun (clear_overrun),
    .o_y             (y),
    .o_y_sat         (y_sat),
    .o_y_valid       (y_valid),
    .o_busy          (busy),
    .o_overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (y_valid) vcount++;

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_y();
    int s = 0;
    for (int k = 0; k < TAPS; k++) s += coef_m[k] * hist[k];
    return s;
  endfunction

  function automatic int model_sat(input int v);
    int q = v >>> 10;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return q;
  endfunction

  function automatic void push(input int v);
    for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = v;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < TAPS; k++) begin
      coef_m[k] = 0;
      hist[k]   = 0;
    end
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic load_coef(input int a, input int d);
    int dv = d;
    coef_we = 1'b1; coef_addr = a[6:0]; coef_data = dv[9:0];
    @(negedge clk);
    coef_we = 1'b0;
    if (a < TAPS) coef_m[a] = d;
  endtask

  // One convolution: optional coefficient write in the ready cycle, optional
  // write to coef[3] mid-convolution, then gap idle cycles after y_valid.
  task automatic run_conv(input int xv, input bit wr_now, input int wa,
                          input int wd, input bit wr_mid, input int gap);
    int lat;
    int ey;
    int dv = wd;
    ready = 1'b1; x = xv[7:0];
    if (wr_now) begin
      coef_we = 1'b1; coef_addr = wa[6:0]; coef_data = dv[9:0];
      if (wa < TAPS) coef_m[wa] = wd;
    end
    push(xv);
    ey = model_y();
    @(negedge clk);
    ready = 1'b0; coef_we = 1'b0;
    lat = 0;
    while (!y_valid && lat < 60) begin
      if (wr_mid && lat == 10) begin
        coef_we = 1'b1; coef_addr = 7'd3; coef_data = 10'd7;
      end else begin
        coef_we = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    coef_we = 1'b0;
    check("latency", lat, 33);
    check("y", longint'($signed(y)), ey);
    check("y_sat", longint'($signed(y_sat)), model_sat(ey));
    check("busy_in_valid", busy, 1);
    if (gap > 0) begin
      @(negedge clk);
      check("valid_pulse", y_valid, 0);
      check("busy_after", busy, 0);
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  initial begin
    int v0;
    model_reset();
    rst_n = 1'b0; ready = 1'b0; x = '0; coef_we = 1'b0; coef_addr = '0;
    coef_data = '0; clear_overrun = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_y", y, 0);
    check("rst_ysat", y_sat, 0);
    check("rst_valid", y_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Impulse response through coef[k] = k+1
    for (int k = 0; k < TAPS; k++) load_coef(k, k + 1);
    run_conv(1, 0, 0, 0, 0, 6);
    for (int n = 0; n < 30; n++) begin
      run_conv(0, 0, 0, 0, 0, 6);
      check("impulse_tap", longint'($signed(y)), n + 2);
    end

    // DC gain, alternating minimum spacing and wider spacing
    for (int k = 0; k < TAPS; k++) load_coef(k, 1);
    for (int n = 1; n <= TAPS; n++) begin
      run_conv(127, 0, 0, 0, 0, (n % 2 == 1) ? 0 : 3);
      if (n == 10) check("dc_ramp", longint'($signed(y)), 1270);
    end
    check("dc_y", longint'($signed(y)), 3937);
    check("dc_ysat", longint'($signed(y_sat)), 3);
    check("min_spacing_no_overrun", overrun, 0);
    @(negedge clk);

    // Saturation both ways
    for (int k = 0; k < TAPS; k++) load_coef(k, 511);
    run_conv(127, 0, 0, 0, 0, 2);
    check("sat_pos_y", longint'($signed(y)), 2011807);
    check("sat_pos", longint'($signed(y_sat)), 127);
    for (int n = 0; n < TAPS; n++) run_conv(-128, 0, 0, 0, 0, 1);
    check("sat_neg_y", longint'($signed(y)), -2027648);
    check("sat_neg", longint'($signed(y_sat)), -128);

    // Coefficient write rules with random coefficients and samples
    for (int k = 0; k < TAPS; k++) load_coef(k, int'($urandom_range(0, 1023)) - 512);
    load_coef(3, 2);
    run_conv(int'($urandom_range(0, 255)) - 128, 0, 0, 0, 1, 2);
    run_conv(int'($urandom_range(0, 255)) - 128, 0, 0, 0, 0, 2);
    run_conv(int'($urandom_range(0, 255)) - 128, 1, 5, -3, 0, 2);
    load_coef(31, 100);
    run_conv(int'($urandom_range(0, 255)) - 128, 0, 0, 0, 0, 2);

    // Overrun: second ready at edge 5, together with clear (set wins)
    v0 = vcount;
    ready = 1'b1; x = 8'd50; push(50);
    @(negedge clk);
    ready = 1'b0;
    repeat (4) @(negedge clk);
    ready = 1'b1; x = 8'd99; clear_overrun = 1'b1;
    @(negedge clk);
    ready = 1'b0; clear_overrun = 1'b0;
    check("overrun_set", overrun, 1);
    repeat (45) @(negedge clk);
    check("overrun_one_valid", vcount - v0, 1);
    check("overrun_y", longint'($signed(y)), model_y());
    check("overrun_sticky", overrun, 1);
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    check("overrun_clear", overrun, 0);
    run_conv(int'($urandom_range(0, 255)) - 128, 0, 0, 0, 0, 2);

    // Random convolutions
    for (int n = 0; n < 8; n++) begin
      if (n == 4) load_coef(int'($urandom_range(0, 30)), int'($urandom_range(0, 1023)) - 512);
      run_conv(int'($urandom_range(0, 255)) - 128, 0, 0, 0, 0, int'($urandom_range(0, 3)));
    end
    @(negedge clk);

    // Reset in the middle of a convolution (after forcing an overrun)
    ready = 1'b1; x = 8'd77;
    @(negedge clk);
    ready = 1'b0;
    repeat (4) @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("pre_reset_overrun", overrun, 1);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_y", y, 0);
    check("midrst_ysat", y_sat, 0);
    check("midrst_overrun", overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    v0 = vcount;
    repeat (40) @(negedge clk);
    check("no_valid_after_reset", vcount - v0, 0);
    for (int k = 0; k < TAPS; k++) load_coef(k, k + 1);
    run_conv(1, 0, 0, 0, 0, 2);
    check("fresh_impulse", longint'($signed(y)), 1);
    run_conv(0, 0, 0, 0, 0, 2);
    check("fresh_impulse2", longint'($signed(y)), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
